// File: rtl/matrix_pkg.sv
// Shared types and constants for the dot-matrix column scan sequencer.
package matrix_pkg;

  localparam int COLS  = 16;
  localparam int ROWS  = 16;
  localparam int COL_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BLANK,
    ST_LOAD,
    ST_STROBE,
    ST_DWELL
  } scan_state_t;

endpackage

// File: rtl/matrix_frame_buffer.sv
// Double-buffered frame store: writes go to the back bank, reads come from the front bank.
module matrix_frame_buffer
  import matrix_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             toggle,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [ROWS-1:0]  wr_data,
  input  logic [COL_W-1:0] rd_addr,
  output logic [ROWS-1:0]  rd_data
);

  logic            front;
  logic [ROWS-1:0] mem [2][COLS];

  // Front-bank selector; flips only when the sequencer commits a swap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      front <= 1'b0;
    end else if (toggle) begin
      front <= ~front;
    end
  end

  // Pixel storage is not reset. A write in the swap cycle still uses the old
  // back bank, which becomes the front bank at the same edge.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[~front][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[front][rd_addr];

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Column scan sequencer: blank/load/strobe/dwell per column, swaps banks only at frame boundaries.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | scan stopped, display blanked, col held at 0
//   ST_BLANK  | BLANK cycles of blanking before a column load
//   ST_LOAD   | column index and data presented to the driver
//   ST_STROBE | COLUMN_CLK high, data held stable
//   ST_DWELL  | column lit for DWELL cycles
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int DWELL = 1000,
  parameter int BLANK = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [ROWS-1:0]  wr_data,
  input  logic             swap_req,
  output logic             swap_ack,
  output logic             frame_start,
  output logic [COL_W-1:0] column_seg,
  output logic [ROWS-1:0]  out_column,
  output logic             COLUMN_CLK,
  output logic             OUT_CLR
);

  localparam int MAX_WAIT = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  scan_state_t      state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             swap_pending_q, swap_pending_d;
  logic             boundary, swap_now;
  logic [ROWS-1:0]  rd_data;

  matrix_frame_buffer u_frame_buffer (
    .CLK     (CLK),
    .RESET   (RESET),
    .toggle  (swap_now),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (col_d),
    .rd_data (rd_data)
  );

  // Next-state, wait-counter reload/decrement, column stepping and swap decision.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_IDLE;
      col_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          col_d   = '0;
          cnt_d   = CNT_W'(BLANK - 1);
        end
        ST_BLANK: begin
          if (cnt_q == '0) state_d = ST_LOAD;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_LOAD: state_d = ST_STROBE;
        ST_STROBE: begin
          state_d = ST_DWELL;
          cnt_d   = CNT_W'(DWELL - 1);
        end
        ST_DWELL: begin
          if (cnt_q == '0) begin
            state_d = ST_BLANK;
            cnt_d   = CNT_W'(BLANK - 1);
            col_d   = col_q + COL_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A request arriving on the boundary cycle itself is honoured there.
    boundary = enable && (state_q == ST_DWELL) && (cnt_q == '0) &&
               (col_q == COL_W'(COLS - 1));
    swap_now = (boundary && (swap_pending_q || swap_req)) ||
               ((state_q == ST_IDLE) && swap_pending_q);
    swap_pending_d = swap_now ? 1'b0 : (swap_pending_q || swap_req);
  end

  // Sequencer state, column index, wait counter and pending swap.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      col_q          <= '0;
      cnt_q          <= '0;
      swap_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      cnt_q          <= cnt_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  // Registered driver outputs, decoded from the state being entered so they line up with it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      column_seg  <= '0;
      out_column  <= '0;
      COLUMN_CLK  <= 1'b0;
      OUT_CLR     <= 1'b1;
      swap_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      OUT_CLR     <= (state_d != ST_DWELL);
      COLUMN_CLK  <= (state_d == ST_STROBE);
      frame_start <= (state_d == ST_LOAD) && (col_d == '0);
      swap_ack    <= swap_now;
      if (state_d == ST_LOAD) begin
        column_seg <= col_d;
        out_column <= rd_data;
      end else if (state_d == ST_IDLE) begin
        column_seg <= '0;
        out_column <= '0;
      end else if (state_d == ST_BLANK) begin
        out_column <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench with a bank model and a column scoreboard for matrix_scan_ctrl.
module tb_matrix_scan_ctrl;
  import matrix_pkg::*;

  localparam int DW = 4;
  localparam int BL = 2;
  localparam int CP = DW + BL + 2;
  localparam int FP = COLS * CP;

  logic             CLK = 1'b0;
  logic             RESET, enable, wr_en, swap_req;
  logic [COL_W-1:0] wr_addr;
  logic [ROWS-1:0]  wr_data;
  logic             swap_ack, frame_start, COLUMN_CLK, OUT_CLR;
  logic [COL_W-1:0] column_seg;
  logic [ROWS-1:0]  out_column;

  always #5 CLK = ~CLK;

  matrix_scan_ctrl #(.DWELL(DW), .BLANK(BL)) dut (
    .CLK(CLK), .RESET(RESET), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .frame_start(frame_start), .column_seg(column_seg), .out_column(out_column),
    .COLUMN_CLK(COLUMN_CLK), .OUT_CLR(OUT_CLR)
  );

  typedef struct packed {
    logic [COL_W-1:0] seg;
    logic [ROWS-1:0]  data;
  } col_t;

  int   total = 0, bad = 0, cyc = 0;
  logic [ROWS-1:0] mb [2][COLS];
  logic m_front, m_pend, m_idle, exp_ack, prev_clk;
  col_t sbq [$];
  int   b_cyc, prev_strobe, prev_fs, ack_cnt = 0, low_run = 0;
  bit   skip_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_frame();
    for (int c = 0; c < COLS; c++) begin
      col_t e;
      e.seg  = COL_W'(c);
      e.data = mb[m_front][c];
      sbq.push_back(e);
    end
  endtask

  task automatic model_reset();
    m_front = 1'b0; m_pend = 1'b0; m_idle = 1'b1;
    sbq.delete();
    b_cyc = -1; prev_strobe = -1; prev_fs = -1; prev_clk = 1'b0;
  endtask

  // One clock: advance the model over the coming edge, then check the outputs.
  task automatic step();
    logic en_in, req_in, we_in, rst_in, bnd, swp;
    logic [COL_W-1:0] wa_in;
    logic [ROWS-1:0]  wd_in;
    en_in = enable; req_in = swap_req; we_in = wr_en; rst_in = RESET;
    wa_in = wr_addr; wd_in = wr_data;
    @(negedge CLK);
    cyc++;
    exp_ack = 1'b0;
    if (rst_in) begin
      model_reset();
    end else begin
      bnd = (cyc == b_cyc) && en_in;
      swp = (bnd && (m_pend || req_in)) || (m_idle && m_pend);
      if (we_in) mb[~m_front][wa_in] = wd_in;
      m_pend = swp ? 1'b0 : (m_pend || req_in);
      if (swp) begin
        m_front = ~m_front;
        exp_ack = 1'b1;
      end
      if (!en_in) begin
        sbq.delete();
        b_cyc = -1; prev_strobe = -1; prev_fs = -1;
      end else if (m_idle || bnd) begin
        push_frame();
      end
      m_idle = !en_in;
    end

    chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
    if (swap_ack) ack_cnt++;
    if (COLUMN_CLK) begin
      chk("strobe_width_prev_low", 32'(prev_clk), 32'(1'b0));
      chk("blank_during_strobe", 32'(OUT_CLR), 32'(1'b1));
      chk("sb_has_entry", 32'(sbq.size() > 0), 32'(1'b1));
      if (sbq.size() > 0) begin
        col_t e;
        e = sbq.pop_front();
        chk("column_seg", 32'(column_seg), 32'(e.seg));
        chk("out_column", 32'(out_column), 32'(e.data));
      end
      if (prev_strobe >= 0) chk("column_period", 32'(cyc - prev_strobe), 32'(CP));
      prev_strobe = cyc;
      if (column_seg == COL_W'(COLS - 1)) b_cyc = cyc + 1 + DW;
    end
    prev_clk = COLUMN_CLK;
    if (frame_start) begin
      chk("frame_start_col", 32'(column_seg), 32'(0));
      if (prev_fs >= 0) chk("frame_period", 32'(cyc - prev_fs), 32'(FP));
      prev_fs = cyc;
    end
    if (!OUT_CLR) begin
      low_run++;
    end else if (low_run > 0) begin
      if (!skip_run) chk("dwell_length", 32'(low_run), 32'(DW));
      skip_run = 0;
      low_run  = 0;
    end
  endtask

  task automatic wait_strobe(input int seg, input int budget);
    bit found = 0;
    int n = 0;
    while (!found && n < budget) begin
      step();
      n++;
      if (COLUMN_CLK && column_seg == COL_W'(seg)) found = 1;
    end
    chk($sformatf("reach_strobe_col%0d", seg), 32'(found), 32'(1'b1));
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1; step(); swap_req = 1'b0;
  endtask

  initial begin
    int a0, r, n;
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < COLS; c++) mb[b][c] = '0;
    RESET = 1'b1; enable = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
    wr_addr = '0; wr_data = '0;
    model_reset();
    repeat (3) step();
    RESET = 1'b0;

    // Idle after reset: blanked, nothing strobed.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_OUT_CLR", 32'(OUT_CLR), 32'(1'b1));
      chk("idle_COLUMN_CLK", 32'(COLUMN_CLK), 32'(1'b0));
      chk("idle_column_seg", 32'(column_seg), 32'(0));
      chk("idle_out_column", 32'(out_column), 32'(0));
    end

    // Load back bank with a walking one, swap while idle.
    for (int c = 0; c < COLS; c++) begin
      wr_en = 1'b1; wr_addr = COL_W'(c); wr_data = 16'h0001 << c; step();
    end
    wr_en = 1'b0;
    pulse_swap();
    repeat (3) step();
    chk("idle_swap_ack_count", 32'(ack_cnt), 32'(1));

    // Scan: column 5 data, then deferred swap issued during column 7.
    enable = 1'b1;
    wait_strobe(5, 100);
    chk("col5_data", 32'(out_column), 32'(16'h0020));
    wait_strobe(7, 40);
    pulse_swap();
    for (int c = 0; c < COLS; c++) begin
      wr_en = 1'b1; wr_addr = COL_W'(c); wr_data = 16'hFFFF; step();
    end
    wr_en = 1'b0;
    n = 0;
    while (ack_cnt < 2 && n < 200) begin step(); n++; end
    chk("deferred_swap_ack_count", 32'(ack_cnt), 32'(2));
    wait_strobe(0, 20);
    chk("after_swap_col0", 32'(out_column), 32'(16'hFFFF));

    // Swap request and write to column 0 on the boundary cycle itself.
    wait_strobe(15, 200);
    n = 0;
    while (cyc != b_cyc - 1 && n < 20) begin step(); n++; end
    chk("reach_boundary_cycle", 32'(cyc), 32'(b_cyc - 1));
    a0 = ack_cnt;
    swap_req = 1'b1; wr_en = 1'b1; wr_addr = '0; wr_data = 16'hA5A5;
    step();
    swap_req = 1'b0; wr_en = 1'b0;
    wait_strobe(0, 20);
    chk("boundary_write_col0", 32'(out_column), 32'(16'hA5A5));
    chk("boundary_swap_ack_count", 32'(ack_cnt - a0), 32'(1));

    // Two requests in one frame give a single swap.
    wait_strobe(2, 40);
    pulse_swap();
    wait_strobe(9, 80);
    a0 = ack_cnt;
    pulse_swap();
    wait_strobe(0, 100);
    chk("double_req_one_swap", 32'(ack_cnt - a0), 32'(1));
    chk("double_req_col0", 32'(out_column), 32'(16'hFFFF));

    // Enable drop during column 3 dwell, then restart from column 0.
    wait_strobe(3, 40);
    step(); step();
    enable = 1'b0; skip_run = 1;
    step();
    chk("drop_OUT_CLR", 32'(OUT_CLR), 32'(1'b1));
    chk("drop_COLUMN_CLK", 32'(COLUMN_CLK), 32'(1'b0));
    chk("drop_column_seg", 32'(column_seg), 32'(0));
    repeat (4) step();
    enable = 1'b1; r = cyc;
    wait_strobe(0, 20);
    chk("restart_latency", 32'(cyc - r), 32'(BL + 2));

    // Async reset in STROBE with a swap pending: pending swap is lost.
    pulse_swap();
    wait_strobe(2, 40);
    a0 = ack_cnt;
    #2 RESET = 1'b1; enable = 1'b0;
    #1;
    chk("rst_OUT_CLR", 32'(OUT_CLR), 32'(1'b1));
    chk("rst_COLUMN_CLK", 32'(COLUMN_CLK), 32'(1'b0));
    chk("rst_column_seg", 32'(column_seg), 32'(0));
    chk("rst_out_column", 32'(out_column), 32'(0));
    chk("rst_frame_start", 32'(frame_start), 32'(1'b0));
    model_reset();
    repeat (3) step();
    RESET = 1'b0;
    repeat (40) step();
    chk("rst_pending_dropped", 32'(ack_cnt - a0), 32'(0));
    enable = 1'b1;
    wait_strobe(15, 200);
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
